avalon_msg_generator: RTL and testbench

Avalon-ST message source. Accepts a command (byte length plus seed) and transmits one well-formed Avalon-ST message on an avalon_st_if master port: sop on the first beat, eop and empty on the last, with an incrementing byte pattern. It honours rdy backpressure.
It is the transmit end of the Avalon-ST message path. Its output must always pass the enforcer/checker path unchanged, with missing_sop and unexpected_sop never asserting. It also serves as the traffic source for the streaming benches.

---
 rtl/avalon_msg_generator.sv | 185 ++++++++++++++++++
 tb/tb_avalon_msg_generator.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/avalon_msg_generator.sv
// Avalon-ST message source: turns a (length, seed) command into one framed message
// with an incrementing byte pattern, honouring downstream backpressure.
module avalon_msg_generator #(
  parameter int unsigned DATA_WIDTH_IN_BYTES = 16,
  parameter int unsigned LEN_WIDTH           = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cmd_valid,
  output logic                                   cmd_rdy,
  input  logic [LEN_WIDTH-1:0]                   cmd_len,
  input  logic [7:0]                             cmd_seed,
  output logic [DATA_WIDTH_IN_BYTES*8-1:0]       msg_out_data,
  output logic                                   msg_out_valid,
  input  logic                                   msg_out_rdy,
  output logic                                   msg_out_sop,
  output logic                                   msg_out_eop,
  output logic [$clog2(DATA_WIDTH_IN_BYTES)-1:0] msg_out_empty,
  output logic                                   busy,
  output logic                                   zero_len_err,
  output logic [15:0]                            msg_count
);

  localparam int unsigned DATA_W  = DATA_WIDTH_IN_BYTES * 8;
  localparam int unsigned EMPTY_W = $clog2(DATA_WIDTH_IN_BYTES);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]           state_q, state_d;
  logic                 cmd_rdy_q, cmd_rdy_d;
  logic                 busy_q, busy_d;
  logic                 zero_len_err_q, zero_len_err_d;
  logic [15:0]          msg_count_q, msg_count_d;
  logic                 valid_q, valid_d;
  logic                 sop_q, sop_d;
  logic                 eop_q, eop_d;
  logic [EMPTY_W-1:0]   empty_q, empty_d;
  logic [DATA_W-1:0]    data_q, data_d;
  // Value of the first byte of the next beat still to be presented.
  logic [7:0]           next_byte_q, next_byte_d;
  // Beats not yet presented on the bus.
  logic [LEN_WIDTH-1:0] beats_rem_q, beats_rem_d;
  logic [EMPTY_W-1:0]   last_empty_q, last_empty_d;

  logic                 cmd_accept;
  logic [LEN_WIDTH:0]   len_round;
  logic [LEN_WIDTH-1:0] cmd_beats;
  logic [EMPTY_W-1:0]   cmd_last_empty;
  logic                 is_last;

  assign cmd_accept     = cmd_valid & cmd_rdy_q;
  // One extra bit so the ceil rounding cannot overflow at the maximum length.
  assign len_round      = {1'b0, cmd_len} + (LEN_WIDTH + 1)'(DATA_WIDTH_IN_BYTES - 1);
  assign cmd_beats      = LEN_WIDTH'(len_round >> EMPTY_W);
  assign cmd_last_empty = '0 - cmd_len[EMPTY_W-1:0];

  // First message byte sits in the most significant lane; empty lanes are zeroed.
  function automatic logic [DATA_W-1:0] build_beat(input logic [7:0]         first,
                                                   input logic [EMPTY_W-1:0] empty);
    logic [DATA_W-1:0] beat;
    int unsigned       n_valid;
    beat    = '0;
    n_valid = DATA_WIDTH_IN_BYTES - int'(empty);
    for (int unsigned i = 0; i < DATA_WIDTH_IN_BYTES; i++) begin
      if (i < n_valid) begin
        beat[(DATA_WIDTH_IN_BYTES - 1 - i) * 8 +: 8] = first + 8'(i);
      end
    end
    return beat;
  endfunction

  always_comb begin
    state_d        = state_q;
    cmd_rdy_d      = cmd_rdy_q;
    busy_d         = busy_q;
    zero_len_err_d = 1'b0;
    msg_count_d    = msg_count_q;
    valid_d        = valid_q;
    sop_d          = sop_q;
    eop_d          = eop_q;
    empty_d        = empty_q;
    data_d         = data_q;
    next_byte_d    = next_byte_q;
    beats_rem_d    = beats_rem_q;
    last_empty_d   = last_empty_q;
    is_last        = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd_rdy_d = 1'b1;
        busy_d    = 1'b0;
        if (cmd_accept) begin
          if (cmd_len == '0) begin
            zero_len_err_d = 1'b1;
          end else begin
            is_last      = (cmd_beats == LEN_WIDTH'(1));
            state_d      = SEND;
            cmd_rdy_d    = 1'b0;
            busy_d       = 1'b1;
            valid_d      = 1'b1;
            sop_d        = 1'b1;
            eop_d        = is_last;
            empty_d      = is_last ? cmd_last_empty : '0;
            data_d       = build_beat(cmd_seed, is_last ? cmd_last_empty : '0);
            next_byte_d  = cmd_seed + 8'(DATA_WIDTH_IN_BYTES);
            beats_rem_d  = cmd_beats - LEN_WIDTH'(1);
            last_empty_d = cmd_last_empty;
          end
        end
      end

      SEND: begin
        if (valid_q && msg_out_rdy) begin
          if (eop_q) begin
            state_d     = IDLE;
            cmd_rdy_d   = 1'b1;
            busy_d      = 1'b0;
            valid_d     = 1'b0;
            sop_d       = 1'b0;
            eop_d       = 1'b0;
            empty_d     = '0;
            data_d      = '0;
            msg_count_d = msg_count_q + 16'd1;
          end else begin
            is_last     = (beats_rem_q == LEN_WIDTH'(1));
            sop_d       = 1'b0;
            eop_d       = is_last;
            empty_d     = is_last ? last_empty_q : '0;
            data_d      = build_beat(next_byte_q, is_last ? last_empty_q : '0);
            next_byte_d = next_byte_q + 8'(DATA_WIDTH_IN_BYTES);
            beats_rem_d = beats_rem_q - LEN_WIDTH'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cmd_rdy_q      <= 1'b0;
      busy_q         <= 1'b0;
      zero_len_err_q <= 1'b0;
      msg_count_q    <= '0;
      valid_q        <= 1'b0;
      sop_q          <= 1'b0;
      eop_q          <= 1'b0;
      empty_q        <= '0;
      data_q         <= '0;
      next_byte_q    <= '0;
      beats_rem_q    <= '0;
      last_empty_q   <= '0;
    end else begin
      state_q        <= state_d;
      cmd_rdy_q      <= cmd_rdy_d;
      busy_q         <= busy_d;
      zero_len_err_q <= zero_len_err_d;
      msg_count_q    <= msg_count_d;
      valid_q        <= valid_d;
      sop_q          <= sop_d;
      eop_q          <= eop_d;
      empty_q        <= empty_d;
      data_q         <= data_d;
      next_byte_q    <= next_byte_d;
      beats_rem_q    <= beats_rem_d;
      last_empty_q   <= last_empty_d;
    end
  end

  assign cmd_rdy       = cmd_rdy_q;
  assign busy          = busy_q;
  assign zero_len_err  = zero_len_err_q;
  assign msg_count     = msg_count_q;
  assign msg_out_valid = valid_q;
  assign msg_out_sop   = sop_q;
  assign msg_out_eop   = eop_q;
  assign msg_out_empty = empty_q;
  assign msg_out_data  = data_q;

endmodule

// File: tb/tb_avalon_msg_generator.sv
// Directed bench for avalon_msg_generator at 16-byte beats with hand-computed beats.
module tb_avalon_msg_generator;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_rdy;
  logic [15:0]  cmd_len;
  logic [7:0]   cmd_seed;
  logic [127:0] msg_out_data;
  logic         msg_out_valid;
  logic         msg_out_rdy;
  logic         msg_out_sop;
  logic         msg_out_eop;
  logic [3:0]   msg_out_empty;
  logic         busy;
  logic         zero_len_err;
  logic [15:0]  msg_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  avalon_msg_generator #(
    .DATA_WIDTH_IN_BYTES(16),
    .LEN_WIDTH          (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_rdy      (cmd_rdy),
    .cmd_len      (cmd_len),
    .cmd_seed     (cmd_seed),
    .msg_out_data (msg_out_data),
    .msg_out_valid(msg_out_valid),
    .msg_out_rdy  (msg_out_rdy),
    .msg_out_sop  (msg_out_sop),
    .msg_out_eop  (msg_out_eop),
    .msg_out_empty(msg_out_empty),
    .busy         (busy),
    .zero_len_err (zero_len_err),
    .msg_count    (msg_count)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Outputs are sampled and inputs driven 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [15:0] len, input logic [7:0] seed);
    cmd_valid = 1'b1;
    cmd_len   = len;
    cmd_seed  = seed;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic check_beat(input string tag, input logic sop, input logic eop,
                            input logic [3:0] empty, input logic [127:0] data);
    check({tag, ".valid"}, 128'(msg_out_valid), 128'(1'b1));
    check({tag, ".sop"},   128'(msg_out_sop),   128'(sop));
    check({tag, ".eop"},   128'(msg_out_eop),   128'(eop));
    check({tag, ".empty"}, 128'(msg_out_empty), 128'(empty));
    check({tag, ".data"},  msg_out_data,        data);
  endtask

  task automatic check_idle(input string tag, input logic [15:0] count);
    check({tag, ".valid"},   128'(msg_out_valid), 128'(1'b0));
    check({tag, ".eop"},     128'(msg_out_eop),   128'(1'b0));
    check({tag, ".data"},    msg_out_data,        128'h0);
    check({tag, ".cmd_rdy"}, 128'(cmd_rdy),       128'(1'b1));
    check({tag, ".busy"},    128'(busy),          128'(1'b0));
    check({tag, ".count"},   128'(msg_count),     128'(count));
  endtask

  localparam logic [127:0] B40_0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] B40_1 = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] B40_2 = 128'h20212223242526270000000000000000;

  initial begin
    int cyc;
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_len     = '0;
    cmd_seed    = '0;
    msg_out_rdy = 1'b1;
    tick();
    tick();
    check("rst.valid",   128'(msg_out_valid), 128'(1'b0));
    check("rst.cmd_rdy", 128'(cmd_rdy),       128'(1'b0));
    check("rst.busy",    128'(busy),          128'(1'b0));
    check("rst.zle",     128'(zero_len_err),  128'(1'b0));
    check("rst.count",   128'(msg_count),     128'(0));
    check("rst.data",    msg_out_data,        128'h0);
    rst = 1'b0;
    tick();
    check("post_rst.cmd_rdy", 128'(cmd_rdy), 128'(1'b1));

    // Test 1: single-beat message
    send_cmd(16'd1, 8'ha5);
    check_beat("t1.b0", 1'b1, 1'b1, 4'd15, {8'ha5, 120'h0});
    check("t1.cmd_rdy", 128'(cmd_rdy), 128'(1'b0));
    check("t1.busy",    128'(busy),    128'(1'b1));
    tick();
    check_idle("t1.end", 16'd1);

    // Test 2: 40 bytes -> 3 beats
    send_cmd(16'd40, 8'h00);
    check_beat("t2.b0", 1'b1, 1'b0, 4'd0, B40_0);
    tick();
    check_beat("t2.b1", 1'b0, 1'b0, 4'd0, B40_1);
    tick();
    check_beat("t2.b2", 1'b0, 1'b1, 4'd8, B40_2);
    tick();
    check_idle("t2.end", 16'd2);

    // Test 3: 32 bytes, seed wraps through 0xff
    send_cmd(16'd32, 8'hf8);
    check_beat("t3.b0", 1'b1, 1'b0, 4'd0, 128'hf8f9fafbfcfdfeff0001020304050607);
    tick();
    check_beat("t3.b1", 1'b0, 1'b1, 4'd0, 128'h08090a0b0c0d0e0f1011121314151617);
    tick();
    check_idle("t3.end", 16'd3);

    // Test 4: stall beat1 for three edges
    send_cmd(16'd40, 8'h00);
    cyc = 0;
    check_beat("t4.b0", 1'b1, 1'b0, 4'd0, B40_0);
    tick();
    cyc++;
    msg_out_rdy = 1'b0;
    check_beat("t4.b1", 1'b0, 1'b0, 4'd0, B40_1);
    for (int i = 0; i < 3; i++) begin
      tick();
      cyc++;
      check_beat("t4.b1_hold", 1'b0, 1'b0, 4'd0, B40_1);
    end
    msg_out_rdy = 1'b1;
    tick();
    cyc++;
    check_beat("t4.b2", 1'b0, 1'b1, 4'd8, B40_2);
    check("t4.eop_latency", 128'(cyc), 128'(5));
    tick();
    check_idle("t4.end", 16'd4);

    // Test 5: zero-length command, then a command held high across a message
    send_cmd(16'd0, 8'h33);
    check("t5.zle",       128'(zero_len_err),  128'(1'b1));
    check("t5.zle_valid", 128'(msg_out_valid), 128'(1'b0));
    check("t5.zle_rdy",   128'(cmd_rdy),       128'(1'b1));
    tick();
    check("t5.zle_pulse", 128'(zero_len_err),  128'(1'b0));
    check_idle("t5.zle_end", 16'd4);

    cmd_valid = 1'b1;
    cmd_len   = 16'd40;
    cmd_seed  = 8'h10;
    tick();
    cmd_len  = 16'd16;
    cmd_seed = 8'h77;
    check_beat("t5.b0", 1'b1, 1'b0, 4'd0, 128'h101112131415161718191a1b1c1d1e1f);
    tick();
    check_beat("t5.b1", 1'b0, 1'b0, 4'd0, 128'h202122232425262728292a2b2c2d2e2f);
    check("t5.b1_rdy", 128'(cmd_rdy), 128'(1'b0));
    tick();
    check_beat("t5.b2", 1'b0, 1'b1, 4'd8, 128'h30313233343536370000000000000000);
    tick();
    check_idle("t5.gap", 16'd5);
    tick();
    cmd_valid = 1'b0;
    check_beat("t5.next", 1'b1, 1'b1, 4'd0, 128'h7778797a7b7c7d7e7f80818283848586);
    tick();
    check_idle("t5.end", 16'd6);

    // Test 6: reset during beat1, with downstream stalled
    send_cmd(16'd40, 8'h00);
    tick();
    msg_out_rdy = 1'b0;
    check_beat("t6.b1", 1'b0, 1'b0, 4'd0, B40_1);
    rst = 1'b1;
    tick();
    rst         = 1'b0;
    msg_out_rdy = 1'b1;
    check("t6.valid",   128'(msg_out_valid), 128'(1'b0));
    check("t6.eop",     128'(msg_out_eop),   128'(1'b0));
    check("t6.count",   128'(msg_count),     128'(0));
    check("t6.cmd_rdy", 128'(cmd_rdy),       128'(1'b0));
    tick();
    check_idle("t6.after", 16'd0);
    tick();
    check_idle("t6.quiet", 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
